// File: rtl/inst_fetch_if.sv
// inst_fetch_if: fetch request/response handshakes, flush and program-load port
interface inst_fetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  flush;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_fault;
    logic                  load_en;
    logic [ADDR_WIDTH-1:0] load_addr;
    logic [DATA_WIDTH-1:0] load_data;
    modport master (
        output req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
        input  req_ready, rsp_valid, rsp_data, rsp_fault
    );
    modport slave (
        input  req_valid, req_addr, flush, rsp_ready, load_en, load_addr, load_data,
        output req_ready, rsp_valid, rsp_data, rsp_fault
    );
endinterface

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: instruction memory with pipelined valid/ready read port, flush and load port
module inst_fetch_mem #(
    parameter int    ADDR_WIDTH   = 32,
    parameter int    DATA_WIDTH   = 32,
    parameter int    DEPTH_WORDS  = 65536,
    parameter int    READ_LATENCY = 1,
    parameter string MEM_FILE     = "mips_hex/7-jump.mem"
) (
    input logic         clk,
    input logic         rst_n,
    inst_fetch_if.slave bus
);
    localparam int IW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    localparam int L  = READ_LATENCY;
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [ADDR_WIDTH-1:0] idx, load_idx;
    logic                  fault, advance;
    logic [L-1:0]          v, f;
    logic [DATA_WIDTH-1:0] d [L];

    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
    end

    assign idx           = bus.req_addr >> 2;
    assign load_idx      = bus.load_addr >> 2;
    assign fault         = (bus.req_addr[1:0] != 2'b0) || (idx >= ADDR_WIDTH'(DEPTH_WORDS));
    assign advance       = !bus.rsp_valid || bus.rsp_ready;
    assign bus.req_ready = advance && !bus.flush;
    assign bus.rsp_valid = v[L-1];
    assign bus.rsp_fault = f[L-1];
    assign bus.rsp_data  = d[L-1];

    always_ff @(posedge clk)
        if (bus.load_en && load_idx < ADDR_WIDTH'(DEPTH_WORDS))
            mem[load_idx[IW-1:0]] <= bus.load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            f <= '0;
            for (int i = 0; i < L; i++) d[i] <= '0;
        end else if (bus.flush) begin
            v <= '0;
        end else if (advance) begin
            v[0] <= bus.req_valid;
            f[0] <= fault;
            d[0] <= fault ? '0 : mem[idx[IW-1:0]];
            for (int i = 1; i < L; i++) begin
                v[i] <= v[i-1];
                f[i] <= f[i-1];
                d[i] <= d[i-1];
            end
        end
    end
endmodule
